shift_deser: RTL and testbench
==============================

// Module: shift_deser
// PURPOSE
//  Serial-in/parallel-out receiver; the far end of our parallel-load shift register (4-bit load, serial bit out).
//  Collects WIDTH serial bits, LSB first, into a word and presents it on a valid/ready output port.
//  Double-buffered: the shift register keeps filling while the output word waits for the consumer.
//  Sits between the serial link and word-level logic on the single system clock.
// PARAMETERS
//  WIDTH   4   data bits per frame, 2..32
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  sin_valid   in   1      sin_bit/sin_start are sampled this cycle
//  sin_bit     in   1      serial data bit (w of the transmitter)
//  sin_start   in   1      marks the first bit of a frame; qualified by sin_valid
//  dout        out  WIDTH  received word
//  dout_valid  out  1      dout holds an unconsumed word
//  dout_ready  in   1      consumer takes dout when dout_valid&dout_ready
//  overrun     out  1      1-cycle pulse: completed word dropped, buffer full
//  frame_err   out  1      1-cycle pulse: sin_start arrived mid-frame
// BEHAVIOUR
//  - Clock is clk; reset is synchronous, active-high (rst). Only one clock domain.
//  - Reset: state=IDLE, bit count=0, shift reg=0, dout=0, dout_valid=0, overrun=0, frame_err=0 (parity_err=0).
//  - Bits shift in at the MSB (sreg <= {sin_bit, sreg[WIDTH-1:1]}): after b0..b(W-1), word = {b(W-1)..b0}.
//  - Cycles with sin_valid=0 are ignored in every state; no timeout.
//  - IDLE: sin_valid&sin_start -> capture bit0, cnt=1, go SHIFT. sin_valid without sin_start is discarded.
//  - SHIFT: each sin_valid shifts one bit, cnt+1. When the WIDTH-th bit is taken -> word complete,
//    go IDLE (or PARITY when PARITY_CHECK_EN). cnt width = $clog2(WIDTH+1).
//  - SHIFT + sin_valid&sin_start: frame_err pulses next cycle; partial frame discarded;
//    this bit becomes bit0 of a new frame, cnt=1, stay SHIFT.
//  - Word complete: on the next edge dout<=word and dout_valid<=1. Latency is 1 cycle after the final bit.
//  - Handshake: dout_valid stays high, and dout holds stable, until dout_valid&dout_ready; then it clears.
//  - Completion and handoff in the same cycle: the new word loads, and dout_valid stays 1 (no bubble, no overrun).
//  - Completion while dout_valid=1 with no handoff that cycle: the new word is dropped, dout is unchanged,
//    and overrun pulses.
//  - Reset mid-frame or with dout_valid=1: everything returns to reset values; the partial word and the held word are lost.
//  - A frame of WIDTH=2 back-to-back sin_start every other bit is legal (no idle gap needed).
// CONFIGURATION
//  - PARITY_CHECK_EN defined: adds state PARITY and output port parity_err (out, 1).
//    After the data bits, the next sin_valid bit is even parity over the data bits.
//    The word is then presented, even if parity mismatches, and parity_err pulses with the dout_valid rise.
//    On a dropped word, parity_err does not pulse. sin_start in PARITY is handled as mid-frame (frame_err).
//  - Not defined: no PARITY state and no parity_err port; the frame is exactly WIDTH bits.
// STRUCTURE
//  - Package shift_pkg: state typedef (IDLE, SHIFT, PARITY), localparam MAX_WIDTH=32.
//  - One sub-module, shift_deser_obuf: the output word register plus the valid/ready/overrun logic.
//  - The top level keeps the FSM, the bit counter and the shift register.
// TESTING (WIDTH=4, parity off unless stated)
//  1. Reset, then start+bits 1,0,1,1 on consecutive cycles -> next cycle dout=4'b1101, dout_valid=1.
//  2. Same frame with sin_valid gaps of 3 idle cycles between bits -> same dout=4'b1101, no errors.
//  3. dout_ready=0, send 2 frames (0xA, then 0x5) -> dout stays 0xA, overrun pulses once after frame 2.
//  4. Hold dout_ready=1, send back-to-back frames 0x3, 0xC -> each valid for 1 handshake, no overrun.
//  5. Start, 2 bits, then start+bits 0,1,1,1 -> frame_err pulse, dout=4'b1110.
//  6. PARITY_CHECK_EN: data 0xB, parity bit 0 -> dout=0xB, parity_err=1; parity bit 1 -> parity_err=0.
//     Also assert rst mid-frame -> all outputs 0.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// Shared types and limits for the shift_deser serial receiver.
package shift_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    // Receiver frame states; StParity only reachable when PARITY_CHECK_EN is defined.
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } state_e;

endpackage

// File: rtl/shift_deser_if.sv
// Bus bundle for shift_deser: serial input side plus the word-level valid/ready output side.
// Macro PARITY_CHECK_EN adds the parity_err signal.
interface shift_deser_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
);
    logic             sin_valid;
    logic             sin_bit;
    logic             sin_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             frame_err;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
`endif

    // Producer of serial bits / consumer of words.
    modport master (
        output sin_valid,
        output sin_bit,
        output sin_start,
        output dout_ready,
`ifdef PARITY_CHECK_EN
        input  parity_err,
`endif
        input  dout,
        input  dout_valid,
        input  overrun,
        input  frame_err
    );

    // The receiver itself.
    modport slave (
        input  sin_valid,
        input  sin_bit,
        input  sin_start,
        input  dout_ready,
`ifdef PARITY_CHECK_EN
        output parity_err,
`endif
        output dout,
        output dout_valid,
        output overrun,
        output frame_err
    );

endinterface

// File: rtl/shift_deser_obuf.sv
// Output word buffer for shift_deser: holds one completed word until the consumer takes it.
// Macro PARITY_CHECK_EN adds the parity error flag carried alongside the word.
module shift_deser_obuf #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
`ifdef PARITY_CHECK_EN
    input  logic             perr_i,
    output logic             parity_err_o,
`endif
    input  logic             ready_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             handoff;
`ifdef PARITY_CHECK_EN
    logic             perr_q, perr_d;
`endif

    assign handoff = valid_q & ready_i;

    // Next-state: accept a new word if the slot is empty or being emptied, else drop it.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_d    = 1'b0;
`endif
        if (load_i) begin
            if (!valid_q || handoff) begin
                dout_d  = word_i;
                valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_d  = perr_i;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handoff) begin
            valid_d = 1'b0;
        end
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign dout_o    = dout_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
`ifdef PARITY_CHECK_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: rtl/shift_deser.sv
// shift_deser: serial-in/parallel-out receiver, LSB first, double-buffered valid/ready output.
// Macro PARITY_CHECK_EN adds a trailing even-parity bit per frame and the parity_err output.
module shift_deser
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    shift_deser_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : gen_width_chk
        $error("shift_deser: WIDTH out of range");
    end

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             ferr_q, ferr_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             done;
    logic             perr;

    // New bits enter at the MSB so the first bit ends up in bit 0.
    assign shifted = {bus.sin_bit, sreg_q[WIDTH-1:1]};

    // Frame FSM: bit counting, restart on mid-frame start, word completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
        word    = shifted;
        perr    = 1'b0;
        if (bus.sin_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.sin_start) begin
                        sreg_d  = shifted;
                        cnt_d   = CntW'(1);
                        state_d = StShift;
                    end
                end
                StShift: begin
                    sreg_d = shifted;
                    if (bus.sin_start) begin
                        ferr_d = 1'b1;
                        cnt_d  = CntW'(1);
                    end else if (cnt_q == CntW'(WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = StParity;
`else
                        done    = 1'b1;
                        state_d = StIdle;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    if (bus.sin_start) begin
                        ferr_d  = 1'b1;
                        sreg_d  = shifted;
                        cnt_d   = CntW'(1);
                        state_d = StShift;
                    end else begin
                        // Data is already complete in sreg_q; this bit is the even parity.
                        done    = 1'b1;
                        word    = sreg_q;
                        perr    = bus.sin_bit ^ (^sreg_q);
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM, counter and shift register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.frame_err = ferr_q;

`ifndef PARITY_CHECK_EN
    logic unused_perr;
    assign unused_perr = perr;
`endif

    shift_deser_obuf #(
        .WIDTH(WIDTH)
    ) u_obuf (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (done),
        .word_i      (word),
`ifdef PARITY_CHECK_EN
        .perr_i      (perr),
        .parity_err_o(bus.parity_err),
`endif
        .ready_i     (bus.dout_ready),
        .dout_o      (bus.dout),
        .valid_o     (bus.dout_valid),
        .overrun_o   (bus.overrun)
    );

endmodule

// File: tb/tb_shift_deser.sv
// Testbench for shift_deser: directed frames plus random traffic, scoreboard-checked.
module tb_shift_deser;

    localparam int unsigned WIDTH = 4;
`ifdef PARITY_CHECK_EN
    localparam int unsigned FLEN = WIDTH + 1;
`else
    localparam int unsigned FLEN = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;

    shift_deser_if #(.WIDTH(WIDTH)) bus ();

    shift_deser #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame = list of bits, output slot = full flag, accepted words queued.
    bit               m_bits[$];
    bit               m_active = 1'b0;
    bit               m_full   = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    bit               e_ovr  = 1'b0;
    bit               e_ferr = 1'b0;
    bit               mon_en = 1'b0;
    bit               m_done;
    bit               m_handoff;
    bit               m_par;
    logic [WIDTH-1:0] m_word;
`ifdef PARITY_CHECK_EN
    bit               e_perr = 1'b0;
    bit               m_pe;
`endif

    always @(posedge clk) begin
        e_ovr  = 1'b0;
        e_ferr = 1'b0;
`ifdef PARITY_CHECK_EN
        e_perr = 1'b0;
        m_pe   = 1'b0;
`endif
        if (rst) begin
            m_bits.delete();
            m_active = 1'b0;
            m_full   = 1'b0;
            exp_q.delete();
        end else begin
            m_done    = 1'b0;
            m_handoff = m_full && bus.dout_ready;
            if (bus.sin_valid) begin
                if (bus.sin_start) begin
                    e_ferr = m_active;
                    m_bits.delete();
                    m_bits.push_back(bus.sin_bit);
                    m_active = 1'b1;
                end else if (m_active) begin
                    m_bits.push_back(bus.sin_bit);
                end
                if (m_active && m_bits.size() == FLEN) begin
                    m_word = '0;
                    m_par  = 1'b0;
                    for (int i = 0; i < WIDTH; i++) begin
                        m_word = m_word + (WIDTH'(m_bits[i]) << i);
                        m_par  = m_par ^ m_bits[i];
                    end
`ifdef PARITY_CHECK_EN
                    m_pe = (m_bits[WIDTH] != m_par);
`endif
                    m_done   = 1'b1;
                    m_active = 1'b0;
                    m_bits.delete();
                end
            end
            if (m_done) begin
                if (!m_full || m_handoff) begin
                    exp_q.push_back(m_word);
                    m_full = 1'b1;
`ifdef PARITY_CHECK_EN
                    e_perr = m_pe;
`endif
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (m_handoff) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires words on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("dout_valid", 32'(bus.dout_valid), 32'(m_full));
            chk("overrun", 32'(bus.overrun), 32'(e_ovr));
            chk("frame_err", 32'(bus.frame_err), 32'(e_ferr));
`ifdef PARITY_CHECK_EN
            chk("parity_err", 32'(bus.parity_err), 32'(e_perr));
`endif
            if (bus.dout_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("dout_unexpected", 32'(bus.dout_valid), 32'(0));
                end else begin
                    chk("dout", 32'(bus.dout), 32'(exp_q[0]));
                    if (bus.dout_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic b, input logic s);
        bus.sin_valid  = v;
        bus.sin_bit    = b;
        bus.sin_start  = s;
        bus.dout_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Sends one frame (plus correct even parity when enabled) with gap idle cycles between bits.
    task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, w[i], i == 0);
            if (i != WIDTH - 1) idle(gap);
        end
`ifdef PARITY_CHECK_EN
        idle(gap);
        step(1'b1, ^w, 1'b0);
`endif
    endtask

    initial begin
        bus.sin_valid  = 1'b0;
        bus.sin_bit    = 1'b0;
        bus.sin_start  = 1'b0;
        bus.dout_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("reset_dout", 32'(bus.dout), 32'(0));
        chk("reset_valid", 32'(bus.dout_valid), 32'(0));

        // Consecutive bits 1,0,1,1.
        rdy = 1'b0;
        send_word(4'b1101, 0);
        chk("t1_dout", 32'(bus.dout), 32'(4'b1101));
        chk("t1_valid", 32'(bus.dout_valid), 32'(1));
        rdy = 1'b1;
        idle(2);

        // Same frame with 3-cycle gaps.
        rdy = 1'b0;
        send_word(4'b1101, 3);
        chk("t2_dout", 32'(bus.dout), 32'(4'b1101));
        rdy = 1'b1;
        idle(2);

        // Two frames with no consumer: second is dropped.
        rdy = 1'b0;
        send_word(4'hA, 0);
        send_word(4'h5, 0);
        chk("t3_overrun", 32'(bus.overrun), 32'(1));
        chk("t3_dout", 32'(bus.dout), 32'(4'hA));
        idle(3);
        rdy = 1'b1;
        idle(2);

        // Back-to-back frames with consumer always ready.
        rdy = 1'b1;
        send_word(4'h3, 0);
        send_word(4'hC, 0);
        chk("t4_dout", 32'(bus.dout), 32'(4'hC));
        idle(2);

        // Mid-frame restart.
        rdy = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        send_word(4'b1110, 0);
        chk("t5_dout", 32'(bus.dout), 32'(4'b1110));
        rdy = 1'b1;
        idle(2);

`ifdef PARITY_CHECK_EN
        // Data 0xB has odd weight, so a parity bit of 0 is wrong.
        rdy = 1'b1;
        for (int i = 0; i < WIDTH; i++) step(1'b1, i != 2, i == 0);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_dout", 32'(bus.dout), 32'(4'hB));
        chk("t6_perr_bad", 32'(bus.parity_err), 32'(1));
        idle(1);
        for (int i = 0; i < WIDTH; i++) step(1'b1, i != 2, i == 0);
        step(1'b1, 1'b1, 1'b0);
        chk("t6_perr_ok", 32'(bus.parity_err), 32'(0));
        idle(1);
`endif

        // Reset mid-frame with a held word.
        rdy = 1'b0;
        send_word(4'h6, 0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_dout", 32'(bus.dout), 32'(0));
        chk("rst_valid", 32'(bus.dout_valid), 32'(0));
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(2);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0);
        end
        rst = 1'b0;
        rdy = 1'b1;
        idle(4);
        chk("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
